seq_event_monitor: RTL
======================

Name: seq_event_monitor

Overview:
- Downstream consumer of the Moore "111" sequence detector. Takes the detector's level output Y on the det input.
- Converts each distinct detection run, meaning each contiguous interval with det high, into one event.
- Counts events, measures each run's length in cycles, and raises a sticky interrupt when the event count reaches a programmed threshold.
- Gives the control/status logic a per-event pulse instead of a raw level.

Parameters:
CNT_W, 8, width of event counter evt_count
LEN_W, 8, width of run-length counter and last_len
THRESH, 4, event count that sets irq; legal range 1 .. 2^CNT_W-1 (checked by elaboration assertion)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (reset==0 resets all state immediately; release is synchronous to clk)
det  input  1  detector level output, sampled on every rising edge of clk
ack  input  1  interrupt acknowledge, single-cycle, synchronous
clr  input  1  synchronous clear of counters and irq
evt_pulse  output  1  one-cycle pulse, once per det run
evt_count  output  CNT_W  saturating count of events since reset/clr
last_len  output  LEN_W  length in cycles of the most recently completed run
irq  output  1  sticky threshold interrupt
busy  output  1  high while a run is in progress

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, run_len=0, evt_count=0, last_len=0, irq=0. All outputs are 0.
- FSM is Moore with states IDLE, START, RUN. All outputs are registered or decoded from the state only, with no combinational path from det.
  - IDLE: det=1 -> START; det=0 -> IDLE.
  - START: det=1 -> RUN; det=0 -> IDLE.
  - RUN: det=1 -> RUN; det=0 -> IDLE.
- evt_pulse = (state==START). Latency: det first sampled high at edge k -> evt_pulse high during the cycle after edge k, for exactly one cycle.
- busy = (state!=IDLE).
- run_len (internal):
  - IDLE with det=1: load 1.
  - START/RUN with det=1: run_len+1, saturating at 2^LEN_W-1.
  - START/RUN with det=0: last_len <= run_len and run_len <= 0.
  - run_len equals the number of det-high samples in the run.
- evt_count:
  - Increments on the IDLE->START transition, so the new value is visible in the same cycle as evt_pulse.
  - Saturates at 2^CNT_W-1 with no wrap.
- irq:
  - Set on the transition whose incremented evt_count value equals THRESH.
  - Set at most once per clr/reset epoch, because evt_count passes THRESH only once.
  - Held until ack=1, then clears on the next edge.
  - Set and ack in the same cycle: set wins.
  - ack while irq=0: no effect.
- clr=1 (sync): evt_count<=0, last_len<=0, irq<=0. It has priority over the increment, set and last_len capture of that same edge.
  - FSM state and run_len are unaffected, so a run in progress continues.
  - An event starting on the clr edge is dropped from evt_count, but evt_pulse still fires.
- Boundaries:
  - A run that ends without a gap starts a new event only after at least one det=0 sample (IDLE).
  - det toggling 1,0,1,0 produces one event per 1, each with last_len=1.
  - Asserting reset mid-run discards the run; last_len is not updated.
  - If det is already high at reset release, this counts as a new event on the first edge.

Decomposition:
- Package seq_mon_pkg holds typedef enum logic [1:0] {IDLE, START, RUN} mon_state_t.
- Sub-module sat_counter (parameter W; ports clk, reset, clr, inc, load1; output q): saturating up-counter.
  - Instantiated twice: evt_count uses inc/clr; run_len uses load1/inc/clear-on-exit.
- Top keeps the FSM, last_len register and irq flag.

Test Plan:
- Reset: hold reset=0 with det=1 -> all outputs 0. Release with det still 1 -> evt_pulse=1 one cycle later, evt_count=1, busy=1.
- Single run: det high 5 cycles then low -> exactly one evt_pulse, evt_count=1, busy high 5 cycles, last_len=5 one cycle after det falls.
- Threshold: 4 separate runs of length 3 with 2-cycle gaps -> irq rises in the same cycle as the 4th evt_pulse (evt_count=4). A 5th run leaves irq set; ack=1 -> irq=0 next cycle, and a 6th run does not re-set it.
- Ack/set collision, clr: pulse ack in the same cycle irq is being set -> irq=1. Apply clr mid-run (run length 6) -> evt_count=0 and irq=0 immediately after; at run end last_len=6 and busy drops.
- Saturation (LEN_W=3, CNT_W=2, THRESH=3): det high 12 cycles -> last_len=7. Run 5 events -> evt_count stops at 3 with no wrap.
- Reset mid-run: det high 4 cycles, then reset=0 asynchronously mid-cycle -> outputs clear without waiting for a clock edge, and last_len stays 0.

Source files
------------

// File: rtl/seq_mon_pkg.sv
// ============================================================================
// Module   : seq_mon_pkg
// Brief    : Shared types for the detector event monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2
   } mon_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_event_monitor_if.sv
// ============================================================================
// Module   : seq_event_monitor_if
// Brief    : Detector input, control strobes and event status bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_event_monitor_if #(
   parameter int CNT_W = 8,
   parameter int LEN_W = 8
);
   logic             det;
   logic             ack;
   logic             clr;
   logic             evt_pulse;
   logic [CNT_W-1:0] evt_count;
   logic [LEN_W-1:0] last_len;
   logic             irq;
   logic             busy;

   modport master (
      output det, ack, clr,
      input  evt_pulse, evt_count, last_len, irq, busy
   );

   modport slave (
      input  det, ack, clr,
      output evt_pulse, evt_count, last_len, irq, busy
   );
endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones; clr beats load1 beats inc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int W = 8
) (
   input  wire logic         clk,
   input  wire logic         reset,
   input  wire logic         clr,
   input  wire logic         inc,
   input  wire logic         load1,
   output logic      [W-1:0] q
);

   localparam logic [W-1:0] c_MAX = '1;

   logic [W-1:0] r_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (load1) begin
         r_q <= W'(1);
      end else if (inc && (r_q != c_MAX)) begin
         r_q <= r_q + W'(1);
      end
   end

   assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/seq_event_monitor.sv
// ============================================================================
// Module   : seq_event_monitor
// Brief    : Turns each det-high run into one event; counts, measures, alerts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_event_monitor
   import seq_mon_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int LEN_W  = 8,
   parameter int THRESH = 4
) (
   input  wire logic          clk,
   input  wire logic          reset,
   seq_event_monitor_if.slave bus
);

   generate
      if ((THRESH < 1) || (THRESH > ((2 ** CNT_W) - 1))) begin : g_bad_thresh
         $error("seq_event_monitor: THRESH out of range 1..2^CNT_W-1");
      end
   endgenerate

   // irq fires when the pre-increment count sits one below the threshold
   localparam logic [CNT_W-1:0] c_THRESH_M1 = CNT_W'(THRESH - 1);

   mon_state_t       r_state;
   logic             r_evt_pulse;
   logic             r_busy;
   logic             r_irq;
   logic [LEN_W-1:0] r_last_len;

   logic             w_start;
   logic             w_in_run;
   logic             w_run_inc;
   logic             w_run_end;
   logic             w_set;
   logic [CNT_W-1:0] w_evt_count;
   logic [LEN_W-1:0] w_run_len;

   assign w_start   = (r_state == IDLE) && bus.det;
   assign w_in_run  = (r_state != IDLE);
   assign w_run_inc = w_in_run && bus.det;
   assign w_run_end = w_in_run && !bus.det;
   assign w_set     = w_start && (w_evt_count == c_THRESH_M1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_evt_pulse <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_evt_pulse <= 1'b0;
         r_busy      <= bus.det;
         case (r_state)
            IDLE: begin
               if (bus.det) begin
                  r_state     <= START;
                  r_evt_pulse <= 1'b1;
               end
            end
            START:   r_state <= bus.det ? RUN : IDLE;
            RUN:     r_state <= bus.det ? RUN : IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_evt_count (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.clr),
      .inc   (w_start),
      .load1 (1'b0),
      .q     (w_evt_count)
   );

   sat_counter #(.W(LEN_W)) u_run_len (
      .clk   (clk),
      .reset (reset),
      .clr   (w_run_end),
      .inc   (w_run_inc),
      .load1 (w_start),
      .q     (w_run_len)
   );

   // clr outranks both the capture and the set taking place on the same edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last_len <= '0;
         r_irq      <= 1'b0;
      end else if (bus.clr) begin
         r_last_len <= '0;
         r_irq      <= 1'b0;
      end else begin
         if (w_run_end) begin
            r_last_len <= w_run_len;
         end
         if (w_set) begin
            r_irq <= 1'b1;
         end else if (bus.ack) begin
            r_irq <= 1'b0;
         end
      end
   end

   assign bus.evt_pulse = r_evt_pulse;
   assign bus.evt_count = w_evt_count;
   assign bus.last_len  = r_last_len;
   assign bus.irq       = r_irq;
   assign bus.busy      = r_busy;

endmodule

`default_nettype wire
